// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network input stage: encoder FSM states,
// LFSR tap constants and per-channel seed derivation.
package snn_pkg;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_RUN  = 2'd1,
        ENC_DONE = 2'd2
    } enc_state_e;

    // Galois right-shift taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [15:0] SEED_STRIDE  = 16'h1F35;

    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            16:      taps = {16'h0000, LFSR_TAPS_16};
            32:      taps = 32'h8020_0003;
            default: taps = {16'h0000, LFSR_TAPS_16};
        endcase
        return taps;
    endfunction

    // Seed for channel idx, truncated to width; an all-zero state would lock up.
    function automatic logic [31:0] channel_seed(input logic [31:0] base, input int idx,
                                                 input int width);
        logic [63:0] mask;
        logic [63:0] raw;
        mask = (width >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        raw  = (64'(base) + 64'(idx) * 64'(SEED_STRIDE)) & mask;
        if (raw == 64'd0) begin
            raw = 64'd1;
        end
        return raw[31:0];
    endfunction

endpackage

// File: rtl/snn_rate_encoder_lfsr.sv
// One Galois LFSR (module snn_lfsr); exposes only the low sample bits used for
// the spike comparison.
module snn_lfsr
    import snn_pkg::*;
#(
    parameter int                SAMPLE_WIDTH = 8,
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  TAPS         = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0]  SEED         = WIDTH'(16'hACE1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    advance,
    output logic [SAMPLE_WIDTH-1:0] sample
);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] state_nxt_s;

    // Galois step: shift right, fold taps in when the outgoing bit is set.
    always_comb begin
        state_nxt_s = {1'b0, state_r[WIDTH-1:1]};
        if (state_r[0]) begin
            state_nxt_s = {1'b0, state_r[WIDTH-1:1]} ^ TAPS;
        end else begin
            state_nxt_s = {1'b0, state_r[WIDTH-1:1]};
        end
    end

    // State register; reseed has priority over stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SEED;
        end else if (load) begin
            state_r <= SEED;
        end else if (advance) begin
            state_r <= state_nxt_s;
        end
    end

    assign sample = state_r[SAMPLE_WIDTH-1:0];

endmodule

// File: rtl/snn_rate_encoder.sv
// Rate-coding input stage: stored pixels become per-timestep spikes for a
// programmed window. Optional spike counter enabled by SNN_ENC_SPIKE_COUNT_EN.
module snn_rate_encoder
    import snn_pkg::*;
#(
    parameter int          NUM_INPUTS  = 1,
    parameter int          PIXEL_WIDTH = 8,
    parameter int          LFSR_WIDTH  = 16,
    parameter int          STEP_WIDTH  = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int         AW          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_wr_en,
    input  logic [AW-1:0]          pix_wr_addr,
    input  logic [PIXEL_WIDTH-1:0] pix_wr_data,
    input  logic [STEP_WIDTH-1:0]  num_steps,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_INPUTS-1:0]  spike_out,
    output logic                   spike_valid,
    output logic [31:0]            spike_count
);

    enc_state_e              state_r, state_nxt_s;
    logic [PIXEL_WIDTH-1:0]  pix_r [NUM_INPUTS];
    logic [PIXEL_WIDTH-1:0]  sample_s [NUM_INPUTS];
    logic [STEP_WIDTH-1:0]   steps_r, step_r;
    logic [NUM_INPUTS-1:0]   spike_nxt_s, spike_out_r;
    logic                    busy_r, done_r, spike_valid_r;
    logic                    busy_nxt_s, done_nxt_s, valid_nxt_s;
    logic                    accept_s, launch_s, run_s, last_step_s;

    assign run_s       = (state_r == ENC_RUN);
    assign accept_s    = (state_r == ENC_IDLE) && start;
    assign launch_s    = accept_s && (num_steps != {STEP_WIDTH{1'b0}});
    assign last_step_s = (step_r == steps_r - STEP_WIDTH'(1'b1));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ENC_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ENC_IDLE: begin
                if (!start) begin
                    state_nxt_s = ENC_IDLE;
                end else if (num_steps == {STEP_WIDTH{1'b0}}) begin
                    state_nxt_s = ENC_DONE;
                end else begin
                    state_nxt_s = ENC_RUN;
                end
            end
            ENC_RUN: begin
                if (last_step_s) begin
                    state_nxt_s = ENC_DONE;
                end else begin
                    state_nxt_s = ENC_RUN;
                end
            end
            ENC_DONE: state_nxt_s = ENC_IDLE;
            default:  state_nxt_s = ENC_IDLE;
        endcase
    end

    // FSM outputs; spikes lag RUN by one cycle, so busy and done are stretched to match.
    always_comb begin
        busy_nxt_s  = (state_nxt_s == ENC_RUN) || run_s;
        done_nxt_s  = ((state_r == ENC_DONE) && busy_r) ||
                      (accept_s && (num_steps == {STEP_WIDTH{1'b0}}));
        valid_nxt_s = run_s;
    end

    // Registered handshake and spike outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            spike_valid_r <= 1'b0;
            spike_out_r   <= {NUM_INPUTS{1'b0}};
        end else begin
            busy_r        <= busy_nxt_s;
            done_r        <= done_nxt_s;
            spike_valid_r <= valid_nxt_s;
            spike_out_r   <= run_s ? spike_nxt_s : {NUM_INPUTS{1'b0}};
        end
    end

    // Window length latch and timestep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps_r <= {STEP_WIDTH{1'b0}};
            step_r  <= {STEP_WIDTH{1'b0}};
        end else if (launch_s) begin
            steps_r <= num_steps;
            step_r  <= {STEP_WIDTH{1'b0}};
        end else if (run_s) begin
            step_r  <= step_r + STEP_WIDTH'(1'b1);
        end
    end

    // Pixel register file; frozen for the whole window, unmatched addresses drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pix_r[i] <= {PIXEL_WIDTH{1'b0}};
            end
        end else if (pix_wr_en && !busy_r) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (pix_wr_addr == AW'(i)) begin
                    pix_r[i] <= pix_wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
        localparam logic [31:0] CH_SEED = channel_seed(32'(SEED), g, LFSR_WIDTH);
        localparam logic [31:0] CH_TAPS = lfsr_taps(LFSR_WIDTH);

        snn_lfsr #(
            .SAMPLE_WIDTH (PIXEL_WIDTH),
            .WIDTH        (LFSR_WIDTH),
            .TAPS         (CH_TAPS[LFSR_WIDTH-1:0]),
            .SEED         (CH_SEED[LFSR_WIDTH-1:0])
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .load    (launch_s),
            .advance (run_s),
            .sample  (sample_s[g])
        );

        assign spike_nxt_s[g] = (sample_s[g] < pix_r[g]);
    end

`ifdef SNN_ENC_SPIKE_COUNT_EN
    logic [31:0] count_r;
    logic [32:0] count_sum_s;

    function automatic logic [31:0] popcount(input logic [NUM_INPUTS-1:0] v);
        logic [31:0] c;
        c = 32'd0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

    assign count_sum_s = {1'b0, count_r} + {1'b0, popcount(spike_out_r)};

    // Saturating spike total, cleared on every accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (accept_s) begin
            count_r <= 32'd0;
        end else if (spike_valid_r) begin
            count_r <= count_sum_s[32] ? 32'hFFFF_FFFF : count_sum_s[31:0];
        end
    end

    assign spike_count = count_r;
`else
    assign spike_count = 32'd0;
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign spike_valid = spike_valid_r;
    assign spike_out   = spike_out_r;

endmodule

// File: tb/tb_snn_rate_encoder.sv
// Self-checking bench for snn_rate_encoder (4 channels): vector table, random
// frames against a behavioural model, and reset / busy-write corner sequences.
module tb_snn_rate_encoder;

    localparam int NI = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_wr_en;
    logic [1:0]    pix_wr_addr;
    logic [7:0]    pix_wr_data;
    logic [15:0]   num_steps;
    logic          start;
    logic          busy, done, spike_valid;
    logic [NI-1:0] spike_out;
    logic [31:0]   spike_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]    mpix [NI];
    logic [NI-1:0] exp_q[$];
    logic [NI-1:0] obs_q[$];
    logic [NI-1:0] first_q[$];
    int            cum[$];

    typedef struct {
        logic [7:0] p0, p1, p2, p3;
        bit         wr;
        int         n;
        bit         disturb;
        int         exp_valid;
        int         exp_done;
    } vec_t;

    vec_t tbl [6];

    snn_rate_encoder #(.NUM_INPUTS(NI)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_wr_en   (pix_wr_en),
        .pix_wr_addr (pix_wr_addr),
        .pix_wr_data (pix_wr_data),
        .num_steps   (num_steps),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .spike_out   (spike_out),
        .spike_valid (spike_valid),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference seeds: base plus channel stride, modulo 2^16, never zero.
    function automatic logic [15:0] seed_of(input int i);
        logic [15:0] v;
        v = 16'hACE1 + 16'(i) * 16'h1F35;
        if (v == 16'd0) v = 16'd1;
        return v;
    endfunction

    // Polynomial x^16+x^14+x^13+x^11+1 in Galois (right-shift) form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    task automatic build_model(input int n);
        logic [15:0]   lf [NI];
        logic [NI-1:0] b;
        logic [7:0]    lo;
        int            total;
        exp_q.delete();
        cum.delete();
        total = 0;
        cum.push_back(0);
        for (int i = 0; i < NI; i++) lf[i] = seed_of(i);
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < NI; i++) begin
                lo   = lf[i][7:0];
                b[i] = (lo < mpix[i]);
                lf[i] = lfsr_next(lf[i]);
            end
            exp_q.push_back(b);
            total += $countones(b);
            cum.push_back(total);
        end
    endtask

    task automatic write_pix(input int i, input logic [7:0] d);
        pix_wr_en   = 1'b1;
        pix_wr_addr = 2'(i);
        pix_wr_data = d;
        @(posedge clk); #1;
        pix_wr_en   = 1'b0;
        mpix[i]     = d;
    endtask

    task automatic run_win(input int n, input bit disturb, input int exp_valid,
                           input int exp_done, input string tag);
        int          vcnt;
        int          idx;
        logic [31:0] exp_cnt;
        build_model(n);
        obs_q.delete();
        vcnt      = 0;
        num_steps = 16'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= n + 4; k++) begin
            pix_wr_en = 1'b0;
            start     = 1'b0;
            if (disturb && k == 5) begin
                pix_wr_en   = 1'b1;
                pix_wr_addr = 2'd1;
                pix_wr_data = ~mpix[1];
                start       = 1'b1;
                num_steps   = 16'd3;
            end
            chk({tag, " busy"}, 32'(busy), 32'(n > 0 && k <= n + 1));
            chk({tag, " done"}, 32'(done), 32'(k == exp_done));
            chk({tag, " valid"}, 32'(spike_valid), 32'(k >= 2 && k <= n + 1));
            if (spike_valid) begin
                vcnt++;
                obs_q.push_back(spike_out);
                if (k >= 2 && (k - 2) < exp_q.size())
                    chk({tag, " spikes"}, 32'(spike_out), 32'(exp_q[k-2]));
            end
            idx = k - 2;
            if (idx < 0) idx = 0;
            if (idx > n) idx = n;
`ifdef SNN_ENC_SPIKE_COUNT_EN
            exp_cnt = 32'(cum[idx]);
`else
            exp_cnt = 32'd0;
`endif
            chk({tag, " count"}, spike_count, exp_cnt);
            @(posedge clk); #1;
        end
        pix_wr_en = 1'b0;
        start     = 1'b0;
        chk({tag, " valid_beats"}, 32'(vcnt), 32'(exp_valid));
    endtask

    initial begin
        int ch [NI];
        int diffs;
        int n;

        rst = 1'b1; pix_wr_en = 1'b0; pix_wr_addr = 2'd0; pix_wr_data = 8'd0;
        num_steps = 16'd0; start = 1'b0;
        for (int i = 0; i < NI; i++) mpix[i] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst valid", 32'(spike_valid), 32'd0);
        chk("rst spikes", 32'(spike_out), 32'd0);
        chk("rst count", spike_count, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        tbl[0] = '{8'd0,   8'd255, 8'd128, 8'd0,   1'b1, 256, 1'b0, 256, 258};
        tbl[1] = '{8'd0,   8'd255, 8'd128, 8'd0,   1'b1, 256, 1'b0, 256, 258};
        tbl[2] = '{8'd10,  8'd200, 8'd50,  8'd90,  1'b1, 0,   1'b0, 0,   1};
        tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 10,  1'b0, 10,  12};
        tbl[4] = '{8'd30,  8'd60,  8'd120, 8'd240, 1'b1, 20,  1'b1, 20,  22};
        tbl[5] = '{8'd30,  8'd60,  8'd120, 8'd240, 1'b0, 1,   1'b0, 1,   3};

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].wr) begin
                write_pix(0, tbl[v].p0);
                write_pix(1, tbl[v].p1);
                write_pix(2, tbl[v].p2);
                write_pix(3, tbl[v].p3);
            end
            run_win(tbl[v].n, tbl[v].disturb, tbl[v].exp_valid, tbl[v].exp_done,
                    $sformatf("vec%0d", v));
            if (v == 0) begin
                first_q = obs_q;
                for (int c = 0; c < NI; c++) ch[c] = 0;
                foreach (obs_q[j]) for (int c = 0; c < NI; c++) ch[c] += int'(obs_q[j][c]);
                chk("stat ch0 zero", 32'(ch[0]), 32'd0);
                chk("stat ch3 zero", 32'(ch[3]), 32'd0);
                chk("stat ch1 ge250", 32'(ch[1] >= 250), 32'd1);
                chk("stat ch2 128pm20", 32'(ch[2] >= 108 && ch[2] <= 148), 32'd1);
            end
            if (v == 1) begin
                diffs = 0;
                chk("repeat length", 32'(obs_q.size()), 32'(first_q.size()));
                foreach (obs_q[j]) if (j < first_q.size() && obs_q[j] !== first_q[j]) diffs++;
                chk("repeat identical", 32'(diffs), 32'd0);
            end
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NI; i++) write_pix(i, 8'($urandom_range(0, 255)));
            n = int'($urandom_range(1, 40));
            run_win(n, 1'b0, n, n + 2, $sformatf("rand%0d", r));
        end

        num_steps = 16'd50;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst valid", 32'(spike_valid), 32'd0);
        chk("midrst spikes", 32'(spike_out), 32'd0);
        chk("midrst count", spike_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) mpix[i] = 8'd0;
        @(posedge clk); #1;
        run_win(8, 1'b0, 8, 10, "postrst_cleared");
        write_pix(0, 8'd200); write_pix(1, 8'd17); write_pix(2, 8'd99); write_pix(3, 8'd255);
        run_win(12, 1'b0, 12, 14, "postrst_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
